asdpmem_reader: RTL and testbench
=================================

// Module: asdpmem_reader
// PURPOSE
//  Burst read engine for the asdpmem read port (addrb/dob). Takes a start
//  address and a length, drives the memory read address and streams the words
//  out on a valid/ready interface with a registered output stage.
//  It is the read-side counterpart to the asdpmem write port and is used to
//  drain packet and line buffers.
// PARAMETERS
//  DEPTH  6   address width; memory holds 2**DEPTH words
//  WIDTH  32  data word width
// PORTS
//  clk        in   1        single clock, rising edge
//  srst_n     in   1        synchronous reset, active low
//  cmd_valid  in   1        burst command present
//  cmd_ready  out  1        engine idle, command can be accepted
//  cmd_addr   in   DEPTH    start word address
//  cmd_len    in   DEPTH+1  burst length in words (0 .. 2**DEPTH)
//  mem_addr   out  DEPTH    to asdpmem addrb (registered)
//  mem_data   in   WIDTH    from asdpmem dob (combinational read)
//  out_valid  out  1        out_data holds a word
//  out_ready  in   1        downstream accepts the word
//  out_data   out  WIDTH    read word
//  out_last   out  1        high with the final word of the burst
//  done       out  1        one-cycle pulse at burst completion
// BEHAVIOUR
//  Reset (srst_n=0 at edge):
//   - state=IDLE; out_valid=0, out_last=0, out_data=0, done=0, mem_addr=0.
//   - Any burst in flight is aborted; no further words are emitted.
//  FSM IDLE/BUSY; cmd_ready = (state==IDLE), combinational.
//  Command accept (cmd_valid & cmd_ready):
//   - len>0: rd_ptr<=cmd_addr, remaining<=len, state->BUSY.
//   - len==0: stay IDLE, done=1 next cycle, no data emitted.
//   - len>2**DEPTH cannot occur (DEPTH+1 bits); the full encoding 2**DEPTH is legal.
//  BUSY datapath:
//   - mem_addr=rd_ptr. Load condition: remaining>0 & (!out_valid | out_ready).
//   - On load: out_data<=mem_data; out_valid<=1; out_last<=(remaining==1);
//     rd_ptr<=rd_ptr+1 mod 2**DEPTH (wraps); remaining<=remaining-1.
//   - Handshake with remaining==0: out_valid<=0.
//  Latency and throughput:
//   - Command accepted at edge N -> first word valid after edge N+1.
//   - One word per cycle while out_ready=1.
//  Backpressure:
//   - While out_valid & !out_ready, out_data, out_last and out_valid hold
//     stable, and rd_ptr/remaining hold.
//  Completion:
//   - At the handshake edge of the out_last word: state->IDLE, out_valid<=0
//     (no new load), done<=1 for exactly one cycle.
//   - cmd_ready rises in the cycle after the last handshake, so back-to-back
//     bursts have a one-cycle gap.
//  Memory hazards:
//   - A write to asdpmem at mem_addr in the load cycle returns the OLD word
//     (write lands on the same edge).
//   - Writes to not-yet-read addresses are visible.
//  The engine never writes memory. Memory contents survive reset.
// TESTING
//  - Mem[i]=i. cmd addr=3, len=4, out_ready=1: data 3,4,5,6 on consecutive
//    cycles starting 2 cycles after accept; out_last only on 6; done 1 cycle.
//  - Wrap: DEPTH=6, addr=62, len=4: data from words 62,63,0,1; mem_addr
//    sequence 62,63,0,1.
//  - Backpressure: len=3, out_ready toggled 1,0,0,1,0,1: data/last stable while
//    stalled; exactly 3 handshakes, no duplicates or drops.
//  - len=0 and len=64 (full memory): len=0 gives done only with out_valid never
//    high; len=64 gives 64 words and out_last on word 64.
//  - Reset mid-burst (srst_n=0 after 2 of 8 words): next cycle out_valid=0,
//    cmd_ready=1. A new cmd addr=10, len=2 then returns words 10,11 only.
//  - Same-cycle write to word being loaded (old=A, new=B): output A; re-read
//    of that word returns B.

Source files
------------

// File: rtl/asdpmem_reader_if.sv
// Burst read bundle for the asdpmem read port:
// command, memory address/data and output stream.
interface asdpmem_reader_if #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 32
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [DEPTH-1:0] cmd_addr;
    logic [DEPTH:0]   cmd_len;
    logic [DEPTH-1:0] mem_addr;
    logic [WIDTH-1:0] mem_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             done;

    modport master (
        input  cmd_valid, cmd_addr, cmd_len,
        input  mem_data, out_ready,
        output cmd_ready, mem_addr,
        output out_valid, out_data, out_last, done
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_len,
        output mem_data, out_ready,
        input  cmd_ready, mem_addr,
        input  out_valid, out_data, out_last, done
    );
endinterface

// File: rtl/asdpmem_reader.sv
// Burst read engine: walks addrb from a start address and
// streams dob words out through a registered valid/ready stage.
module asdpmem_reader #(
    parameter int DEPTH = 6,
    parameter int WIDTH = 32
) (
    input logic              clk,
    input logic              srst_n,
    asdpmem_reader_if.master bus
);
    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state;
    state_t           state_nx;
    logic [DEPTH-1:0] rd_ptr;
    logic [DEPTH:0]   remaining;
    logic             out_valid;
    logic             out_last;
    logic [WIDTH-1:0] out_data;
    logic             done;
    logic             cmd_rdy;
    logic             accept;
    logic             len_zero;
    logic             load;
    logic             hs;
    logic             fin;

    assign bus.cmd_ready = cmd_rdy;
    assign bus.mem_addr  = rd_ptr;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = out_data;
    assign bus.out_last  = out_last;
    assign bus.done      = done;

    always_comb begin
        state_nx = state;
        cmd_rdy  = (state == IDLE);
        accept   = cmd_rdy & bus.cmd_valid;
        len_zero = (bus.cmd_len == '0);
        hs       = out_valid & bus.out_ready;
        fin      = hs & out_last;
        load     = (state == BUSY) & (remaining != '0) &
                   (!out_valid | bus.out_ready);
        unique case (1'b1)
            (state == IDLE): if (accept && !len_zero) state_nx = BUSY;
            (state == BUSY): if (fin) state_nx = IDLE;
            default:         state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) state <= IDLE;
        else         state <= state_nx;
    end

    // A new word is loaded whenever the output slot is free or draining.
    always_ff @(posedge clk) begin
        if (!srst_n) begin
            rd_ptr    <= '0;
            remaining <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= (accept & len_zero) | fin;
            if (accept && !len_zero) begin
                rd_ptr    <= bus.cmd_addr;
                remaining <= bus.cmd_len;
            end
            if (load) begin
                out_data  <= bus.mem_data;
                out_valid <= 1'b1;
                out_last  <= (remaining == (DEPTH+1)'(1));
                rd_ptr    <= rd_ptr + 1'b1;
                remaining <= remaining - (DEPTH+1)'(1);
            end else if (hs) begin
                out_valid <= 1'b0;
                out_last  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_asdpmem_reader.sv
// Directed and randomized bench for the asdpmem burst reader
// against a word-list reference drawn from the bench memory.
module tb_asdpmem_reader;
    localparam int DEPTH = 6;
    localparam int WIDTH = 32;
    localparam int N     = 1 << DEPTH;

    logic clk = 1'b0;
    logic srst_n = 1'b0;
    always #5 clk = ~clk;

    asdpmem_reader_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus ();

    asdpmem_reader #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk    (clk),
        .srst_n (srst_n),
        .bus    (bus)
    );

    logic [WIDTH-1:0] mem [N];
    logic             wr_en = 1'b0;
    logic [DEPTH-1:0] wr_addr = '0;
    logic [WIDTH-1:0] wr_data = '0;

    always @(posedge clk) if (wr_en) mem[wr_addr] <= wr_data;
    assign bus.mem_data = mem[bus.mem_addr];

    int nvec = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input bit rnd);
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            wr_en   = 1'b1;
            wr_addr = DEPTH'(i);
            wr_data = rnd ? $urandom : WIDTH'(i);
        end
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // rmode: 0 always ready, 1 random ready, 2 pattern 1,0,0,1,0,1
    task automatic burst(input int addr, input int len, input int rmode);
        logic [WIDTH-1:0] exp_q[$];
        int pat[6] = '{1, 0, 0, 1, 0, 1};
        int k, cyc, first;
        bit rdy, prev_stall;
        logic [WIDTH-1:0] prev_data;
        logic prev_last;
        for (int i = 0; i < len; i++) exp_q.push_back(mem[(addr + i) % N]);
        @(negedge clk);
        chk("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = DEPTH'(addr);
        bus.cmd_len   = (DEPTH+1)'(len);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        if (len == 0) begin
            chk("len0_done", bus.done, 1);
            chk("len0_valid", bus.out_valid, 0);
            chk("len0_cmd_ready", bus.cmd_ready, 1);
            @(negedge clk);
            chk("len0_done_pulse", bus.done, 0);
            chk("len0_valid2", bus.out_valid, 0);
            return;
        end
        chk("accept_busy", bus.cmd_ready, 0);
        chk("accept_novalid", bus.out_valid, 0);
        chk("accept_mem_addr", bus.mem_addr, addr % N);
        k = 0; cyc = 0; first = -1; prev_stall = 0;
        prev_data = '0; prev_last = 0;
        while (k < len && cyc < 4 * len + 20) begin
            @(negedge clk);
            cyc++;
            if (prev_stall) begin
                chk("stall_valid", bus.out_valid, 1);
                chk("stall_data", bus.out_data, prev_data);
                chk("stall_last", bus.out_last, prev_last);
            end
            if (bus.out_valid && first < 0) begin
                first = cyc;
                chk("first_latency", cyc, 1);
            end
            if (k + int'(bus.out_valid) < len)
                chk("mem_addr", bus.mem_addr,
                    (addr + k + int'(bus.out_valid)) % N);
            unique case (rmode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom % 4) != 0;
                default: rdy = (cyc <= 6) ? pat[cyc-1][0] : 1'b1;
            endcase
            bus.out_ready = rdy;
            if (bus.out_valid && rdy) begin
                if (rmode == 0) chk("throughput", cyc, k + 1);
                chk("data", bus.out_data, exp_q[k]);
                chk("last", bus.out_last, k == len - 1);
                k++;
            end
            prev_stall = bus.out_valid && !rdy;
            prev_data  = bus.out_data;
            prev_last  = bus.out_last;
        end
        if (k < len) chk("burst_timeout", k, len);
        @(negedge clk);
        chk("done_pulse", bus.done, 1);
        chk("end_novalid", bus.out_valid, 0);
        chk("end_cmd_ready", bus.cmd_ready, 1);
        @(negedge clk);
        chk("done_clear", bus.done, 0);
        chk("no_extra_word", bus.out_valid, 0);
        bus.out_ready = 1'b1;
    endtask

    initial begin
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_len   = '0;
        bus.out_ready = 1'b1;
        srst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_valid", bus.out_valid, 0);
        chk("rst_last", bus.out_last, 0);
        chk("rst_data", bus.out_data, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_mem_addr", bus.mem_addr, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        srst_n = 1'b1;

        fill(1'b0);
        burst(3, 4, 0);
        burst(62, 4, 0);
        burst(5, 3, 2);
        burst(17, 0, 0);
        burst(40, 64, 0);

        // Reset in the middle of an 8-word burst.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = DEPTH'(30);
        bus.cmd_len   = (DEPTH+1)'(8);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        chk("mid_w0", bus.out_data, 30);
        @(negedge clk);
        chk("mid_w1", bus.out_data, 31);
        srst_n = 1'b0;
        @(negedge clk);
        srst_n = 1'b1;
        chk("mid_rst_valid", bus.out_valid, 0);
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        chk("mid_rst_done", bus.done, 0);
        chk("mid_rst_data", bus.out_data, 0);
        burst(10, 2, 0);
        repeat (4) begin
            @(negedge clk);
            chk("post_rst_idle", bus.out_valid, 0);
        end

        // Write lands on the same edge the word is loaded.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_addr  = DEPTH'(20);
        bus.cmd_len   = (DEPTH+1)'(1);
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        wr_en   = 1'b1;
        wr_addr = DEPTH'(20);
        wr_data = 32'hB0B0_0014;
        @(negedge clk);
        wr_en = 1'b0;
        chk("hazard_valid", bus.out_valid, 1);
        chk("hazard_old", bus.out_data, 20);
        @(negedge clk);
        chk("hazard_done", bus.done, 1);
        burst(20, 1, 0);
        chk("hazard_mem_new", mem[20], 32'hB0B0_0014);

        fill(1'b1);
        for (int t = 0; t < 12; t++)
            burst($urandom_range(0, N - 1), $urandom_range(0, N), 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
